// File: rtl/alu_flags_reg.sv
// alu_flags_reg: architectural flags register directly downstream of the ALU.
//   Captures the ALU's 5-bit flag vector {lcarry, acarry, zero, sign, overflow}
//   or bus_in[4:0]. Keeps a LIFO shadow stack for interrupt entry and return.
//   Evaluates a 4-bit branch condition code against the stored flags.
//
// Ports:
//   clk, rst_n            : clock; asynchronous active-low reset
//   flags_in, load_alu    : ALU flag vector and its capture strobe
//   bus_in, load_bus      : data bus; bits [4:0] are captured as flags
//   assert_bus            : request to drive the flags onto the bus
//   bus_out, bus_en       : zero-extended flags; active-low driver enable
//   push, pop             : shadow stack save / restore
//   stack_full/empty/err  : stack status; err is sticky until reset
//   cond, cond_true       : condition select and its result (no latency)
//   flags                 : stored flags
module alu_flags_reg #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       flags_in,
  input  logic             load_alu,
  input  logic [WIDTH-1:0] bus_in,
  input  logic             load_bus,
  input  logic             assert_bus,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_en,
  input  logic             push,
  input  logic             pop,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             stack_err,
  input  logic [3:0]       cond,
  output logic             cond_true,
  output logic [4:0]       flags
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [4:0]    flags_q, flags_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [4:0]    stk_q [DEPTH];

  logic          is_full, is_empty;
  logic          push_ok, pop_ok;
  logic [AW-1:0] wr_idx, rd_idx;

  // Only bits [4:0] of the bus carry flags.
  if (WIDTH > 5) begin : g_bus_hi
    logic unused_bus_hi;
    assign unused_bus_hi = ^bus_in[WIDTH-1:5];
  end

  assign is_full  = (cnt_q == FULL_CNT);
  assign is_empty = (cnt_q == '0);

  // push and pop together is an error and moves nothing.
  assign push_ok = push & ~pop & ~is_full;
  assign pop_ok  = pop & ~push & ~is_empty;

  assign wr_idx = AW'(cnt_q);
  assign rd_idx = AW'(cnt_q - 1'b1);

  always_comb begin
    flags_d = flags_q;
    cnt_d   = cnt_q;
    err_d   = err_q | (push & pop) | (push & is_full) | (pop & is_empty);

    if (push_ok) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop_ok) begin
      cnt_d = cnt_q - 1'b1;
    end

    // A successful pop overrides any same-cycle load.
    if (pop_ok) begin
      flags_d = stk_q[rd_idx];
    end else if (load_bus) begin
      flags_d = bus_in[4:0];
    end else if (load_alu) begin
      flags_d = flags_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Stack entries need no reset: anything above the count is never read.
  // The pushed value is the pre-load flags_q, so push+load saves the old flags.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      stk_q[wr_idx] <= flags_q;
    end
  end

  // Condition evaluation from the registered flags only.
  always_comb begin
    logic lc, ac, z, s, v;
    lc = flags_q[4];
    ac = flags_q[3];
    z  = flags_q[2];
    s  = flags_q[1];
    v  = flags_q[0];
    cond_true = 1'b0;
    case (cond)
      4'd0:    cond_true = 1'b1;
      4'd1:    cond_true = z;
      4'd2:    cond_true = ~z;
      4'd3:    cond_true = ac;
      4'd4:    cond_true = ~ac;
      4'd5:    cond_true = lc;
      4'd6:    cond_true = ~lc;
      4'd7:    cond_true = s;
      4'd8:    cond_true = ~s;
      4'd9:    cond_true = v;
      4'd10:   cond_true = ~v;
      4'd11:   cond_true = s ^ v;
      4'd12:   cond_true = ~(s ^ v);
      4'd13:   cond_true = ~ac | z;
      4'd14:   cond_true = ac & ~z;
      default: cond_true = 1'b0;
    endcase
  end

  assign flags       = flags_q;
  assign bus_out     = WIDTH'(flags_q);
  assign bus_en      = ~assert_bus;
  assign stack_full  = is_full;
  assign stack_empty = is_empty;
  assign stack_err   = err_q;

endmodule

// File: tb/tb_alu_flags_reg.sv
module tb_alu_flags_reg;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk;
  logic             rst_n;
  logic [4:0]       flags_in;
  logic             load_alu;
  logic [WIDTH-1:0] bus_in;
  logic             load_bus;
  logic             assert_bus;
  logic [WIDTH-1:0] bus_out;
  logic             bus_en;
  logic             push;
  logic             pop;
  logic             stack_full;
  logic             stack_empty;
  logic             stack_err;
  logic [3:0]       cond;
  logic             cond_true;
  logic [4:0]       flags;

  alu_flags_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flags_in(flags_in), .load_alu(load_alu),
    .bus_in(bus_in), .load_bus(load_bus), .assert_bus(assert_bus),
    .bus_out(bus_out), .bus_en(bus_en), .push(push), .pop(pop),
    .stack_full(stack_full), .stack_empty(stack_empty), .stack_err(stack_err),
    .cond(cond), .cond_true(cond_true), .flags(flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]       f;
    logic             full;
    logic             empty;
    logic             err;
    logic             ct;
    logic             ben;
    logic [WIDTH-1:0] bo;
  } exp_t;

  exp_t       exp_q[$];
  int         n_chk  = 0;
  int         n_fail = 0;

  // Reference model state
  logic [4:0] m_flags;
  logic [4:0] m_stack[$];
  logic       m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Condition table written directly from the named flag meanings.
  function automatic logic cond_ref(input logic [4:0] f, input logic [3:0] c);
    logic lc, ac, z, s, v;
    logic [15:0] tbl;
    {lc, ac, z, s, v} = f;
    tbl = {1'b0, ac && !z, !ac || z, s == v, s != v, !v, v, !s, s,
           !lc, lc, !ac, ac, !z, z, 1'b1};
    return tbl[c];
  endfunction

  // Drive one cycle of stimulus at the falling edge and queue the state the
  // DUT must show after the following rising edge.
  task automatic step(input logic la, input logic [4:0] fi, input logic lb,
                      input logic [WIDTH-1:0] bi, input logic ps, input logic pp,
                      input logic ab, input logic [3:0] cd);
    exp_t       e;
    logic [4:0] nf;
    bit         popped;
    @(negedge clk);
    load_alu = la; flags_in = fi; load_bus = lb; bus_in = bi;
    push = ps; pop = pp; assert_bus = ab; cond = cd;
    nf = m_flags;
    popped = 0;
    if (ps && pp) m_err = 1'b1;
    else if (ps) begin
      if (m_stack.size() == DEPTH) m_err = 1'b1;
      else m_stack.push_back(m_flags);
    end else if (pp) begin
      if (m_stack.size() == 0) m_err = 1'b1;
      else begin
        nf = m_stack.pop_back();
        popped = 1;
      end
    end
    if (!popped) begin
      if (lb) nf = bi[4:0];
      else if (la) nf = fi;
    end
    m_flags = nf;
    e.f     = m_flags;
    e.full  = (m_stack.size() == DEPTH);
    e.empty = (m_stack.size() == 0);
    e.err   = m_err;
    e.ct    = cond_ref(m_flags, cd);
    e.ben   = !ab;
    e.bo    = {{(WIDTH-5){1'b0}}, m_flags};
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic [3:0] cd);
    step(0, 5'h0, 0, '0, 0, 0, 0, cd);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_flags", 32'(flags), 32'h0);
    check("rst_empty", 32'(stack_empty), 32'h1);
    check("rst_full", 32'(stack_full), 32'h0);
    check("rst_err", 32'(stack_err), 32'h0);
    m_flags = '0;
    m_stack.delete();
    m_err = 1'b0;
    load_alu = 0; load_bus = 0; push = 0; pop = 0; assert_bus = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every rising edge, compare the DUT against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("flags", 32'(flags), 32'(e.f));
        check("stack_full", 32'(stack_full), 32'(e.full));
        check("stack_empty", 32'(stack_empty), 32'(e.empty));
        check("stack_err", 32'(stack_err), 32'(e.err));
        check("cond_true", 32'(cond_true), 32'(e.ct));
        check("bus_en", 32'(bus_en), 32'(e.ben));
        check("bus_out", 32'(bus_out), 32'(e.bo));
      end
    end
  end

  initial begin
    logic [4:0] vals[4];
    rst_n = 1'b0; flags_in = '0; load_alu = 0; bus_in = '0; load_bus = 0;
    assert_bus = 0; push = 0; pop = 0; cond = '0;
    m_flags = '0; m_err = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1: mid-cycle reset, then ALU load and bus drive
    do_reset();
    step(1, 5'b10101, 0, '0, 0, 0, 1, 4'd0);
    settle();
    check("tp1_flags", 32'(flags), 32'h15);
    check("tp1_bus_out", 32'(bus_out), 32'h15);
    check("tp1_bus_en", 32'(bus_en), 32'h0);

    // 2: bus load wins over ALU load, then hold
    step(1, 5'b00001, 1, 8'hFE, 0, 0, 0, 4'd1);
    idle(4'd2);
    settle();
    check("tp2_hold", 32'(flags), 32'h1E);

    // 3: fill and drain
    vals = '{5'h01, 5'h02, 5'h04, 5'h08};
    for (int i = 0; i < 4; i++) begin
      step(1, vals[i], 0, '0, 0, 0, 0, 4'd3);
      step(0, 5'h0, 0, '0, 1, 0, 0, 4'd4);
    end
    settle();
    check("tp3_full", 32'(stack_full), 32'h1);
    for (int i = 0; i < 4; i++) begin
      step(0, 5'h0, 0, '0, 0, 1, 0, 4'(5 + i));
      settle();
      check("tp3_pop", 32'(flags), 32'(vals[3 - i]));
    end
    check("tp3_empty", 32'(stack_empty), 32'h1);
    check("tp3_err", 32'(stack_err), 32'h0);

    // 4a: fifth push when full
    for (int i = 0; i < 5; i++) step(1, 5'(i + 3), 0, '0, 1, 0, 0, 4'd9);
    settle();
    check("tp4_full_err", 32'(stack_err), 32'h1);
    check("tp4_full_kept", 32'(stack_full), 32'h1);
    // 4b: pop when empty after reset
    do_reset();
    step(0, 5'h0, 0, '0, 0, 1, 0, 4'd10);
    settle();
    check("tp4_underflow_err", 32'(stack_err), 32'h1);
    check("tp4_underflow_flags", 32'(flags), 32'h0);
    // 4c: push+pop at count 2, then drain to see count stayed 2
    do_reset();
    step(1, 5'h11, 0, '0, 1, 0, 0, 4'd11);
    step(1, 5'h12, 0, '0, 1, 0, 0, 4'd12);
    step(1, 5'h13, 0, '0, 1, 1, 0, 4'd13);
    for (int i = 0; i < 3; i++) step(0, 5'h0, 0, '0, 0, 1, 0, 4'd14);
    settle();
    check("tp4_both_err", 32'(stack_err), 32'h1);

    // 5: push with load
    do_reset();
    step(1, 5'b00100, 0, '0, 0, 0, 0, 4'd0);
    step(1, 5'b01000, 0, '0, 1, 0, 0, 4'd0);
    settle();
    check("tp5_loaded", 32'(flags), 32'h08);
    step(1, 5'h1F, 0, '0, 0, 1, 0, 4'd15);
    settle();
    check("tp5_popped", 32'(flags), 32'h04);

    // 6: condition codes
    step(1, 5'b00010, 0, '0, 0, 0, 0, 4'd11);
    settle();
    check("c11_slt", 32'(cond_true), 32'h1);
    step(0, 5'h0, 0, '0, 0, 0, 0, 4'd12);
    settle();
    check("c12_sge", 32'(cond_true), 32'h0);
    step(1, 5'b01000, 0, '0, 0, 0, 0, 4'd14);
    settle();
    check("c14_hi", 32'(cond_true), 32'h1);
    step(0, 5'h0, 0, '0, 0, 0, 0, 4'd13);
    settle();
    check("c13_ls", 32'(cond_true), 32'h0);
    step(1, 5'b00100, 0, '0, 0, 0, 0, 4'd1);
    settle();
    check("c1_z", 32'(cond_true), 32'h1);
    step(0, 5'h0, 0, '0, 0, 0, 0, 4'd2);
    settle();
    check("c2_nz", 32'(cond_true), 32'h0);
    for (int c = 0; c < 16; c++) idle(4'(c));

    // Random traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      if (n == 300) do_reset();
      step($urandom_range(0, 1), 5'($urandom), $urandom_range(0, 3) == 0,
           8'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 1), 4'($urandom));
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_flags_reg.md
Name: alu_flags_reg

Overview:
- Architectural flags register directly downstream of the ALU.
- Captures the ALU's 5-bit flag vector {lcarry, acarry, zero, sign, overflow} on command.
- Exposes the stored flags on the shared data bus and keeps a small LIFO shadow stack for interrupt entry and return.
- Evaluates a 4-bit branch condition code against the stored flags for the jump logic.

Parameters:
- WIDTH, 8: data bus width; the flags occupy bits [4:0], so WIDTH must be at least 5.
- DEPTH, 4: shadow stack entries; must be at least 1.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst_n  input  1  asynchronous reset, active-low.
- flags_in  input  5  ALU flags {lcarry, acarry, zero, sign, overflow}, bit4..bit0.
- load_alu  input  1  capture flags_in at the next posedge.
- bus_in  input  WIDTH  data bus; bits [4:0] are loaded as flags.
- load_bus  input  1  capture bus_in[4:0] at the next posedge.
- assert_bus  input  1  request to drive the bus with the flags.
- bus_out  output  WIDTH  {zeros, flags}.
- bus_en  output  1  active-low bus driver enable; equals ~assert_bus.
- push  input  1  save the current flags to the shadow stack.
- pop  input  1  restore the flags from the shadow stack.
- stack_full  output  1  stack holds DEPTH entries.
- stack_empty  output  1  stack holds 0 entries.
- stack_err  output  1  sticky error: overflow, underflow, or push and pop together.
- cond  input  4  condition code select.
- cond_true  output  1  selected condition holds for the stored flags.
- flags  output  5  stored flags.

Behaviour:
Reset
- While rst_n=0: flags=0, stack count=0, stack_err=0, stack_empty=1, stack_full=0.
- Stack entry contents are don't-care.
- Reset takes effect immediately, including in the middle of a push or pop.

Combinational outputs
- bus_out = {WIDTH-5 zeros, flags}, always driven.
- bus_en = ~assert_bus.
- cond_true is computed from the registered flags and has no latency.
- Outputs do not depend combinationally on flags_in or bus_in.

Flag register update priority, evaluated at each posedge
- pop and no error: flags <= top-of-stack entry.
- else load_bus: flags <= bus_in[4:0].
- else load_alu: flags <= flags_in.
- else: flags hold.

Stack
- Count register runs 0..DEPTH. The top of stack is entry [count-1].
- Valid push (push=1, pop=0, count<DEPTH): entry[count] <= current registered flags, i.e. the value before any same-cycle load; then count+1.
- push together with load_alu or load_bus: the old flags are pushed and the new value is loaded in the same cycle.
- Valid pop (pop=1, push=0, count>0): flags <= entry[count-1], count-1. A simultaneous load is ignored.
- push=1 and count=DEPTH: no stack change, stack_err <= 1. A same-cycle load still applies.
- pop=1 and count=0: no stack change, stack_err <= 1. A same-cycle load still applies.
- push=1 and pop=1: no stack change, stack_err <= 1. Loads still apply.
- stack_err clears only on reset.
- No wrap-around of count in either direction.

Condition codes (Z=zero, AC=acarry, LC=lcarry, S=sign, V=overflow)
- 0: always 1.
- 1: Z. 2: ~Z.
- 3: AC. 4: ~AC.
- 5: LC. 6: ~LC.
- 7: S. 8: ~S.
- 9: V. 10: ~V.
- 11: S^V (signed less-than).
- 12: ~(S^V) (signed greater-or-equal).
- 13: ~AC | Z (unsigned lower-or-same, with subtraction carry meaning no-borrow).
- 14: AC & ~Z (unsigned higher).
- 15: always 0.

Test Plan:
1. Reset and hold: assert rst_n=0 mid-cycle -> flags=0, stack_empty=1, stack_err=0 immediately, without waiting for a clock edge. Release reset, pulse load_alu with flags_in=5'b10101 -> flags=5'b10101 after one edge. Then with assert_bus=1 -> bus_out=8'h15 and bus_en=0.
2. Load priority: same cycle load_alu=1 with flags_in=5'b00001 and load_bus=1 with bus_in=8'hFE -> flags=5'b11110. Next cycle with no loads -> flags hold 5'b11110.
3. Stack fill and drain: push four distinct values 01, 02, 04, 08 -> stack_full=1. Pop four times -> flags 08, 04, 02, 01 in that order, then stack_empty=1 and stack_err=0.
4. Boundary errors:
   - fifth push when full -> count stays 4, stack_err=1.
   - after reset, pop when empty -> flags unchanged, stack_err=1.
   - push and pop together with count=2 -> count stays 2, stack_err=1.
5. Push with load: flags=5'b00100; push=1 and load_alu=1 with flags_in=5'b01000 -> flags=5'b01000. Subsequent pop -> flags=5'b00100.
6. Conditions:
   - flags S=1, V=0 -> cond 11 gives 1, cond 12 gives 0.
   - flags AC=1, Z=0 -> cond 14 gives 1, cond 13 gives 0.
   - flags Z=1 -> cond 1 gives 1, cond 2 gives 0.
   - any flags -> cond 0 gives 1, cond 15 gives 0.
